mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single RAM access port between two requesters: the instruction-fetch
// path (IF, driven by the controller's load_pc/fetch states) and the load/store
// path (LS, driven by the controller's LDR/STR memory states).
// Allows only one outstanding transaction at a time, sequences the RAM read
// latency and routes read data back to the owning requester.
// Sits between the controller/datapath and the RAM.
// PARAMETERS
// ADDR_W      11  RAM word-address width
// DATA_W      32  RAM data width
// RD_LAT      2   cycles from address presented to ram_rdata valid (>=1)
// STARVE_MAX  4   contested arbitrations IF may lose before it is forced to win (>=1)
// PORTS
// clk        in   1       clock, rising edge
// rst_n      in   1       synchronous active-low reset
// if_req     in   1       IF read request; hold until if_gnt
// if_addr    in   ADDR_W  IF read address
// if_gnt     out  1       one-cycle pulse: IF request accepted (ISSUE cycle)
// if_rvalid  out  1       one-cycle pulse: if_rdata valid
// if_rdata   out  DATA_W  IF read data, held until next IF read completes
// ls_req     in   1       LS request; hold until ls_gnt
// ls_we      in   1       1 = write, 0 = read
// ls_addr    in   ADDR_W  LS address
// ls_wdata   in   DATA_W  LS write data
// ls_gnt     out  1       one-cycle pulse: LS request accepted (ISSUE cycle)
// ls_rvalid  out  1       one-cycle pulse: ls_rdata valid (reads only)
// ls_rdata   out  DATA_W  LS read data, held until next LS read completes
// ram_addr   out  ADDR_W  RAM address, registered, stable ISSUE..end of WAIT
// ram_w_en   out  1       RAM write enable
// ram_wdata  out  DATA_W  RAM write data, registered
// ram_rdata  in   DATA_W  RAM read data
// busy       out  1       state != IDLE
// BEHAVIOUR
// - States: IDLE, ISSUE, WAIT, DONE. Arbitration happens only at edges where the state is IDLE or DONE.
// - At an arbitration edge with any request pending:
//   - latch owner, addr, we and wdata into the output registers.
//   - next state is ISSUE; the owner's gnt is 1 for that cycle only.
// - ISSUE cycle A: ram_addr driven.
//   - Write: ram_w_en=1 for cycle A only; next state IDLE; no rvalid is produced.
//   - Read: ram_w_en=0; next state WAIT.
// - WAIT: lasts exactly RD_LAT cycles (A+1..A+RD_LAT), counted by a down-counter.
//   - At the end of cycle A+RD_LAT, capture ram_rdata into the owner's rdata register.
//   - Next state DONE.
// - DONE (cycle A+RD_LAT+1): the owner's rvalid is 1. A new arbitration may occur at the end of DONE.
// - Read latency: req edge -> gnt is 1 cycle; gnt -> rvalid is RD_LAT+1 cycles.
// - Priority: LS wins when both requesters are active.
//   - starve_cnt increments on each contested arbitration that LS wins.
//   - When starve_cnt == STARVE_MAX, the next contested arbitration goes to IF.
//   - starve_cnt clears whenever IF is granted or if_req=0 at an arbitration edge; it saturates.
// - A request still high in its own gnt cycle is treated as a new request at the next arbitration.
// - ram_w_en=0 in every state except ISSUE-with-write. gnt and rvalid are never high for both ports in the same cycle.
// - Reset (any state, including mid-WAIT): at the edge with rst_n=0, go to IDLE.
//   - All outputs reset to 0: gnt, rvalid, rdata, ram_addr, ram_wdata, ram_w_en, busy.
//   - starve_cnt and the WAIT counter reset to 0.
//   - An in-flight read is dropped and produces no rvalid.
// TESTING
// - Reset: hold rst_n=0 for 2 clocks -> every output is 0 and busy=0; ram_w_en=0 immediately after the reset edge.
// - IF read alone, RD_LAT=2, if_addr=0x010:
//   - if_gnt pulses in cycle A with ram_addr=0x010 and ram_w_en=0.
//   - ram_rdata=0xE3A00001 at A+2 -> if_rvalid=1 at A+3 only, with if_rdata=0xE3A00001.
// - LS write, ls_addr=0x7FF, ls_wdata=0xDEADBEEF -> ram_w_en=1 for exactly 1 cycle with those values; no ls_rvalid; busy=0 the next cycle.
// - IF read and LS read (ls_addr=0x020) raised together:
//   - ls_gnt comes first; ls_rvalid returns the RAM data.
//   - if_gnt follows at the next arbitration, the cycle after ls_rvalid's DONE.
// - Starvation, STARVE_MAX=4, ls_req held high (reads) and if_req high:
//   - LS wins 4 contested arbitrations; IF wins the 5th; LS wins the 6th.
// - Reset mid-WAIT of an IF read -> no if_rvalid, busy=0; a new LS read afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the instruction-fetch (IF) and load/store (LS) requesters.
// One transaction at a time; LS has priority, with a starvation guard for IF.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_en,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned WCW = $clog2(RD_LAT + 1);
    localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e         state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic [SCW-1:0] starve_cnt_q;
    logic           owner_ls_q;
    logic           we_q;

    logic any_req;
    logic grant_if;

    always_comb begin
        any_req  = if_req | ls_req;
        // IF only beats a pending LS once it has lost STARVE_MAX contested rounds
        grant_if = if_req & (~ls_req | (starve_cnt_q == SCW'(STARVE_MAX)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            owner_ls_q   <= 1'b0;
            we_q         <= 1'b0;
            if_gnt       <= 1'b0;
            ls_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            ls_rvalid    <= 1'b0;
            if_rdata     <= '0;
            ls_rdata     <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_w_en     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            ram_w_en  <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (!if_req || grant_if) begin
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q != SCW'(STARVE_MAX)) begin
                        starve_cnt_q <= starve_cnt_q + SCW'(1);
                    end
                    if (any_req) begin
                        state_q <= StIssue;
                        busy    <= 1'b1;
                        if (grant_if) begin
                            owner_ls_q <= 1'b0;
                            we_q       <= 1'b0;
                            if_gnt     <= 1'b1;
                            ram_addr   <= if_addr;
                            ram_wdata  <= '0;
                        end else begin
                            owner_ls_q <= 1'b1;
                            we_q       <= ls_we;
                            ls_gnt     <= 1'b1;
                            ram_addr   <= ls_addr;
                            ram_wdata  <= ls_wdata;
                            ram_w_en   <= ls_we;
                        end
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StIssue: begin
                    if (we_q) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= WCW'(RD_LAT);
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WCW'(1)) begin
                        state_q    <= StDone;
                        wait_cnt_q <= '0;
                        if (owner_ls_q) begin
                            ls_rdata  <= ram_rdata;
                            ls_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= ram_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WCW'(1);
                    end
                end
            endcase
        end
    end

endmodule
